flash_rd_arb: RTL and testbench

//  Two-requester round-robin arbiter and burst sequencer in front of flash_ctrl.

---
 rtl/flash_rd_arb.sv | 200 ++++++++++++++++++++
 tb/tb_flash_rd_arb.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_rd_arb.sv
// Two-requester round-robin arbiter and byte-at-a-time burst sequencer in front of flash_ctrl.
// Each granted burst is issued as back-to-back single-byte reads with a per-byte timeout.
module flash_rd_arb #(
    parameter int unsigned ADDR_NBIT = 24,
    parameter int unsigned DATA_NBIT = 8,
    parameter int unsigned LEN_NBIT  = 16,
    parameter int unsigned TO_CYC    = 4096
) (
    input  logic                 mclk,
    input  logic                 rst_n,
    input  logic                 req0,
    input  logic [ADDR_NBIT-1:0] addr0,
    input  logic [LEN_NBIT-1:0]  len0,
    output logic                 ack0,
    output logic                 dv0,
    output logic                 done0,
    input  logic                 req1,
    input  logic [ADDR_NBIT-1:0] addr1,
    input  logic [LEN_NBIT-1:0]  len1,
    output logic                 ack1,
    output logic                 dv1,
    output logic                 done1,
    output logic [DATA_NBIT-1:0] dout,
    output logic                 err,
    output logic                 frd,
    output logic [ADDR_NBIT-1:0] fraddr,
    input  logic                 frstatus,
    input  logic [DATA_NBIT-1:0] frdata,
    input  logic                 frdv
);

    localparam int unsigned TO_NBIT = (TO_CYC > 2) ? $clog2(TO_CYC) : 1;
    localparam logic [TO_NBIT-1:0] TO_LOAD = TO_NBIT'(TO_CYC - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WSTART, WDATA} state_t;

    state_t                 state_q, state_d;
    logic                   rr_last_q, rr_last_d;
    logic                   owner_q, owner_d;
    logic [ADDR_NBIT-1:0]   cur_addr_q, cur_addr_d;
    logic [LEN_NBIT-1:0]    rem_q, rem_d;
    logic [TO_NBIT-1:0]     to_cnt_q, to_cnt_d;
    logic                   ack0_q, ack0_d, ack1_q, ack1_d;
    logic                   dv0_q, dv0_d, dv1_q, dv1_d;
    logic                   done0_q, done0_d, done1_q, done1_d;
    logic                   err_q, err_d, frd_q, frd_d;
    logic [DATA_NBIT-1:0]   dout_q, dout_d;
    logic [ADDR_NBIT-1:0]   fraddr_q, fraddr_d;
    logic                   gnt;
    logic [LEN_NBIT-1:0]    gnt_len;
    logic                   to_hit;

    always_comb begin
        state_d    = state_q;
        rr_last_d  = rr_last_q;
        owner_d    = owner_q;
        cur_addr_d = cur_addr_q;
        rem_d      = rem_q;
        to_cnt_d   = to_cnt_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        dv0_d      = 1'b0;
        dv1_d      = 1'b0;
        done0_d    = 1'b0;
        done1_d    = 1'b0;
        err_d      = 1'b0;
        frd_d      = 1'b0;
        dout_d     = dout_q;
        fraddr_d   = fraddr_q;
        gnt        = (req0 && req1) ? ~rr_last_q : req1;
        gnt_len    = gnt ? len1 : len0;
        to_hit     = (to_cnt_q == '0);

        unique case (state_q)
            IDLE: begin
                // Requester still sees its req high during the ack cycle; do not re-grant it.
                if (!(ack0_q || ack1_q) && (req0 || req1)) begin
                    rr_last_d  = gnt;
                    owner_d    = gnt;
                    cur_addr_d = gnt ? addr1 : addr0;
                    rem_d      = gnt_len;
                    to_cnt_d   = TO_LOAD;
                    ack0_d     = !gnt;
                    ack1_d     = gnt;
                    if (gnt_len == '0) begin
                        done0_d = !gnt;
                        done1_d = gnt;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (frstatus) begin
                    frd_d    = 1'b1;
                    to_cnt_d = TO_LOAD;
                    state_d  = WSTART;
                end else if (to_hit) begin
                    err_d   = 1'b1;
                    done0_d = !owner_q;
                    done1_d = owner_q;
                    state_d = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q - TO_NBIT'(1);
                end
            end
            WSTART: begin
                // Seeing busy first guards against a stale frdv from the previous byte.
                if (!frstatus) begin
                    state_d = WDATA;
                    if (!to_hit) to_cnt_d = to_cnt_q - TO_NBIT'(1);
                end else if (to_hit) begin
                    err_d   = 1'b1;
                    done0_d = !owner_q;
                    done1_d = owner_q;
                    state_d = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q - TO_NBIT'(1);
                end
            end
            WDATA: begin
                if (frstatus && frdv) begin
                    dout_d     = frdata;
                    dv0_d      = !owner_q;
                    dv1_d      = owner_q;
                    cur_addr_d = cur_addr_q + ADDR_NBIT'(1);
                    rem_d      = rem_q - LEN_NBIT'(1);
                    if (rem_q == LEN_NBIT'(1)) begin
                        done0_d = !owner_q;
                        done1_d = owner_q;
                        state_d = IDLE;
                    end else begin
                        to_cnt_d = TO_LOAD;
                        state_d  = ISSUE;
                    end
                end else if (to_hit) begin
                    err_d   = 1'b1;
                    done0_d = !owner_q;
                    done1_d = owner_q;
                    state_d = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q - TO_NBIT'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d != IDLE) fraddr_d = cur_addr_d;
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_last_q  <= 1'b1;
            owner_q    <= 1'b0;
            cur_addr_q <= '0;
            rem_q      <= '0;
            to_cnt_q   <= '0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            dv0_q      <= 1'b0;
            dv1_q      <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            err_q      <= 1'b0;
            frd_q      <= 1'b0;
            dout_q     <= '0;
            fraddr_q   <= '0;
        end else begin
            state_q    <= state_d;
            rr_last_q  <= rr_last_d;
            owner_q    <= owner_d;
            cur_addr_q <= cur_addr_d;
            rem_q      <= rem_d;
            to_cnt_q   <= to_cnt_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            dv0_q      <= dv0_d;
            dv1_q      <= dv1_d;
            done0_q    <= done0_d;
            done1_q    <= done1_d;
            err_q      <= err_d;
            frd_q      <= frd_d;
            dout_q     <= dout_d;
            fraddr_q   <= fraddr_d;
        end
    end

    assign ack0   = ack0_q;
    assign ack1   = ack1_q;
    assign dv0    = dv0_q;
    assign dv1    = dv1_q;
    assign done0  = done0_q;
    assign done1  = done1_q;
    assign err    = err_q;
    assign frd    = frd_q;
    assign dout   = dout_q;
    assign fraddr = fraddr_q;

endmodule

// File: tb/tb_flash_rd_arb.sv
// Directed bench for flash_rd_arb with a behavioural flash_ctrl stand-in (fixed read latency,
// data = addr[7:0] ^ 0x5A, raddr sampled at the end of the read).
module tb_flash_rd_arb;

    localparam int LAT = 40;

    logic        mclk = 1'b0;
    logic        rst_n;
    logic        req0, req1;
    logic [23:0] addr0, addr1;
    logic [15:0] len0, len1;
    logic        ack0, dv0, done0, ack1, dv1, done1;
    logic [7:0]  dout;
    logic        err, frd;
    logic [23:0] fraddr;
    logic        frstatus = 1'b1;
    logic [7:0]  frdata = 8'h00;
    logic        frdv = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    flash_rd_arb #(.ADDR_NBIT(24), .DATA_NBIT(8), .LEN_NBIT(16), .TO_CYC(64)) dut (
        .mclk(mclk), .rst_n(rst_n),
        .req0(req0), .addr0(addr0), .len0(len0), .ack0(ack0), .dv0(dv0), .done0(done0),
        .req1(req1), .addr1(addr1), .len1(len1), .ack1(ack1), .dv1(dv1), .done1(done1),
        .dout(dout), .err(err), .frd(frd), .fraddr(fraddr),
        .frstatus(frstatus), .frdata(frdata), .frdv(frdv)
    );

    always #5 mclk = ~mclk;

    // flash_ctrl stand-in
    logic        silent = 1'b0;
    logic        m_busy = 1'b0;
    logic        m_track = 1'b0;
    int          m_cnt = 0;
    logic [23:0] m_addr = '0;
    int          addr_slip = 0;
    int          cyc = 0;

    always @(posedge mclk) begin
        cyc <= cyc + 1;
        if (!rst_n) m_track <= 1'b0;
        if (m_busy) begin
            if (m_cnt == 0) begin
                m_busy   <= 1'b0;
                frstatus <= 1'b1;
                frdv     <= 1'b1;
                frdata   <= fraddr[7:0] ^ 8'h5A;
                if (m_track && rst_n && fraddr !== m_addr) addr_slip <= addr_slip + 1;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if (frd && !silent) begin
            m_busy   <= 1'b1;
            m_track  <= 1'b1;
            m_cnt    <= LAT;
            m_addr   <= fraddr;
            frstatus <= 1'b0;
            frdv     <= 1'b0;
        end
    end

    // Event monitor
    logic [7:0]  dq0[$], dq1[$];
    logic [23:0] fq[$];
    int          done_q[$];
    int n_ack0, n_ack1, n_err, n_errdone, n_donedv, n_ackdone0, bad_frd, frd_cyc, err_cyc;

    always @(negedge mclk) begin
        if (rst_n) begin
            if (dv0) dq0.push_back(dout);
            if (dv1) dq1.push_back(dout);
            if (done0) done_q.push_back(0);
            if (done1) done_q.push_back(1);
            if (ack0) n_ack0++;
            if (ack1) n_ack1++;
            if ((done0 && dv0) || (done1 && dv1)) n_donedv++;
            if (ack0 && done0) n_ackdone0++;
            if (err) begin
                n_err++;
                err_cyc = cyc;
                if (done0 || done1) n_errdone++;
            end
            if (frd) begin
                fq.push_back(fraddr);
                frd_cyc = cyc;
                if (m_busy) bad_frd++;
            end
        end
    end

    task automatic clear_mon();
        dq0.delete(); dq1.delete(); fq.delete(); done_q.delete();
        n_ack0 = 0; n_ack1 = 0; n_err = 0; n_errdone = 0; n_donedv = 0; n_ackdone0 = 0;
        bad_frd = 0; frd_cyc = 0; err_cyc = 0; addr_slip = 0;
    endtask

    task automatic do_req(input int n, input logic [23:0] a, input logic [15:0] l);
        bit got = 0;
        if (n == 0) begin req0 = 1'b1; addr0 = a; len0 = l; end
        else        begin req1 = 1'b1; addr1 = a; len1 = l; end
        for (int i = 0; i < 600 && !got; i++) begin
            @(posedge mclk); #1;
            if ((n == 0 && ack0) || (n == 1 && ack1)) got = 1;
        end
        if (n == 0) req0 = 1'b0; else req1 = 1'b0;
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL ack_wait req%0d: no ack, required ack within 600 cycles", n);
        end
    endtask

    task automatic wait_done(input int target);
        int i = 0;
        while (done_q.size() < target && i < 2000) begin
            @(posedge mclk); #1;
            i++;
        end
        n_tests++;
        if (done_q.size() < target) begin
            n_fail++;
            $display("FAIL done_wait: got %0d done pulses, required %0d", done_q.size(), target);
        end
    endtask

    task automatic chk_bytes(input string name, input int n, input logic [7:0] exp[]);
        n_tests++;
        if ((n == 0 ? dq0.size() : dq1.size()) != exp.size()) begin
            n_fail++;
            $display("FAIL %s count: got %0d bytes, required %0d", name,
                     n == 0 ? dq0.size() : dq1.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                logic [7:0] got;
                got = (n == 0) ? dq0[i] : dq1[i];
                n_tests++;
                if (got !== exp[i]) begin
                    n_fail++;
                    $display("FAIL %s byte%0d: got %h, required %h", name, i, got, exp[i]);
                end
            end
        end
    endtask

    task automatic chk_addrs(input string name, input logic [23:0] exp[]);
        n_tests++;
        if (fq.size() != exp.size()) begin
            n_fail++;
            $display("FAIL %s frd count: got %0d, required %0d", name, fq.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                n_tests++;
                if (fq[i] !== exp[i]) begin
                    n_fail++;
                    $display("FAIL %s fraddr%0d: got %h, required %h", name, i, fq[i], exp[i]);
                end
            end
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge mclk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [9:0] outs;
        @(negedge mclk);
        outs = {ack0, dv0, done0, ack1, dv1, done1, err, frd, 2'b00};
        n_tests++;
        if (outs !== 10'b0) begin
            n_fail++; $display("FAIL reset_pulses: got %b, required 0", outs);
        end
        n_tests++;
        if (dout !== 8'h00) begin
            n_fail++; $display("FAIL reset_dout: got %h, required 00", dout);
        end
        n_tests++;
        if (fraddr !== 24'h0) begin
            n_fail++; $display("FAIL reset_fraddr: got %h, required 000000", fraddr);
        end
        @(posedge mclk); #1;
    endtask

    task automatic test_burst();
        clear_mon();
        do_req(0, 24'h000100, 16'd4);
        wait_done(1);
        chk_addrs("burst", '{24'h000100, 24'h000101, 24'h000102, 24'h000103});
        chk_bytes("burst", 0, '{8'h5A, 8'h5B, 8'h58, 8'h59});
        n_tests++;
        if (n_ack0 != 1 || n_donedv != 1 || n_err != 0 || addr_slip != 0) begin
            n_fail++;
            $display("FAIL burst_ctl: ack0=%0d done_with_dv=%0d err=%0d slip=%0d, required 1 1 0 0",
                     n_ack0, n_donedv, n_err, addr_slip);
        end
    endtask

    task automatic run_tie();
        fork
            do_req(0, 24'h000020, 16'd2);
            do_req(1, 24'h000040, 16'd2);
        join
        wait_done(2);
    endtask

    task automatic test_tie();
        pulse_reset();
        clear_mon();
        run_tie();
        n_tests++;
        if (done_q.size() != 2 || done_q[0] != 0 || done_q[1] != 1) begin
            n_fail++; $display("FAIL tie_after_reset: got order %p, required '{0,1}", done_q);
        end
        chk_bytes("tie0", 0, '{8'h7A, 8'h7B});
        chk_bytes("tie1", 1, '{8'h1A, 8'h1B});
        clear_mon();
        do_req(0, 24'h000050, 16'd1);
        wait_done(1);
        clear_mon();
        run_tie();
        n_tests++;
        if (done_q.size() != 2 || done_q[0] != 1 || done_q[1] != 0) begin
            n_fail++; $display("FAIL tie_after_req0: got order %p, required '{1,0}", done_q);
        end
    endtask

    task automatic test_wrap();
        clear_mon();
        do_req(1, 24'hFFFFFE, 16'd3);
        wait_done(1);
        chk_addrs("wrap", '{24'hFFFFFE, 24'hFFFFFF, 24'h000000});
        chk_bytes("wrap", 1, '{8'hA4, 8'hA5, 8'h5A});
        n_tests++;
        if (done_q[0] != 1 || n_donedv != 1) begin
            n_fail++;
            $display("FAIL wrap_done: got done%0d with_dv=%0d, required done1 with_dv=1",
                     done_q[0], n_donedv);
        end
    endtask

    task automatic test_zero_len();
        clear_mon();
        do_req(0, 24'h000123, 16'd0);
        repeat (10) @(posedge mclk);
        #1;
        n_tests++;
        if (n_ack0 != 1 || n_ackdone0 != 1 || done_q.size() != 1 || fq.size() != 0) begin
            n_fail++;
            $display("FAIL zero_len: ack0=%0d ack_with_done=%0d done=%0d frd=%0d, required 1 1 1 0",
                     n_ack0, n_ackdone0, done_q.size(), fq.size());
        end
    endtask

    task automatic test_timeout();
        silent = 1'b1;
        clear_mon();
        do_req(0, 24'h000200, 16'd2);
        wait_done(1);
        n_tests++;
        if (err_cyc - frd_cyc != 64) begin
            n_fail++; $display("FAIL timeout_delay: got %0d cycles, required 64", err_cyc - frd_cyc);
        end
        n_tests++;
        if (n_err != 1 || n_errdone != 1 || dq0.size() != 0 || fq.size() != 1) begin
            n_fail++;
            $display("FAIL timeout_ctl: err=%0d err_with_done=%0d dv=%0d frd=%0d, required 1 1 0 1",
                     n_err, n_errdone, dq0.size(), fq.size());
        end
        silent = 1'b0;
        clear_mon();
        do_req(0, 24'h000010, 16'd1);
        wait_done(1);
        chk_bytes("after_timeout", 0, '{8'h4A});
        n_tests++;
        if (n_err != 0) begin
            n_fail++; $display("FAIL after_timeout_err: got %0d, required 0", n_err);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] outs;
        int i = 0;
        clear_mon();
        do_req(0, 24'h000300, 16'd4);
        while (fq.size() < 2 && i < 1000) begin
            @(posedge mclk); #1;
            i++;
        end
        repeat (5) @(posedge mclk);
        #1 rst_n = 1'b0;
        #1;
        outs = {ack0, dv0, done0, ack1, dv1, done1, err, frd};
        n_tests++;
        if (outs !== 8'b0 || dout !== 8'h00 || fraddr !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_mid: got pulses %b dout %h fraddr %h, required all 0",
                     outs, dout, fraddr);
        end
        @(posedge mclk);
        @(posedge mclk);
        #1 rst_n = 1'b1;
        clear_mon();
        do_req(1, 24'h000400, 16'd2);
        wait_done(1);
        n_tests++;
        if (bad_frd != 0) begin
            n_fail++; $display("FAIL reset_mid_issue: got %0d frd while busy, required 0", bad_frd);
        end
        chk_addrs("reset_mid", '{24'h000400, 24'h000401});
        chk_bytes("reset_mid", 1, '{8'h5A, 8'h5B});
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        addr0 = '0; addr1 = '0; len0 = '0; len1 = '0;
        clear_mon();
        repeat (3) @(posedge mclk);
        #1 rst_n = 1'b1;
        test_reset();
        test_burst();
        test_tie();
        test_wrap();
        test_zero_len();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
